dll_restorer: RTL
=================

Name: dll_restorer

Overview:
- Returns the DRAM from DLL-off, slow-clock operation to DLL-on, full-speed operation; it is the inverse of the DLL-off sequencer.
- Sequence: precharge all, enter self-refresh, switch clock back to fast, exit self-refresh, MRS MR1 with A0=1 (DLL enable), MRS MR0 with A8=1 (DLL reset), wait tDLLK, pulse done.
- Drives the same fabric-side DDR4 command bus (8 fabric lanes per DRAM pin). The top level muxes this bus, and clk_sel, with the other command sources.

Parameters:
- T_PRECHARGE, 5, MC cycles after PREA
- T_CKSRE, 300, MC cycles after SRE before clock switch
- T_CKSRX, 300, MC cycles for clock to stabilise before SRX
- T_XS, 1000, MC cycles after SRX
- T_MOD, 24, MC cycles after each MRS
- T_DLLK, 256, MC cycles after DLL reset (1024 nCK / 4)
- MR0_CONF, 14'h0000, MR0 A[13:0] value; A8 is forced to 1 on issue
- MR1_CONF, 14'b00001100000000, MR1 A[13:0] value; A0 is forced to 1 on issue
- CLK_SEL_FAST, 1'b0, clk_sel level that selects the full-speed clock

Ports:
- clk  in  1  fabric (MC) clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- restore_valid  in  1  start request
- busy  out  1  high whenever state != IDLE
- dlle_done  out  1  one-cycle completion pulse
- mc_ACT_n  out  8  constant all-ones
- mc_ADR  out  17*8  address/RAS(16)/CAS(15)/WE(14) lanes
- mc_BA  out  BANK_WIDTH*8  bank address lanes
- mc_BG  out  BG_WIDTH*8  bank group lanes
- mc_CS_n  out  CS_WIDTH*8  chip select lanes
- mc_CKE  out  CKE_WIDTH*8  clock enable lanes
- clk_sel  out  1  clock source select level

Behaviour:
- Outputs are registered from next-state logic, so each command appears the cycle after its state is entered.
- Default per cycle: ADR all 1, BA/BG all 0, CS_n all 1, CKE holds its value, clk_sel holds its value.
- Commands occupy lanes [1:0] of each pin.
- Async reset: state=IDLE, wait=0, ADR=0, BA=0, BG=0, CS_n all 1, CKE all 1, clk_sel=~CLK_SEL_FAST, busy=0, dlle_done=0.
- Reset mid-sequence aborts immediately to these values; no cleanup commands are issued.
- Wait counter is 11-bit; all T_* must be < 2048. A wait state loads T, decrements each cycle, and leaves when the counter reads 0, so it lasts T+1 cycles.
- States and transitions:
  - IDLE: if restore_valid, issue PREA (CS_n=0, RAS=0, CAS=1, WE=0, A10=1), load T_PRECHARGE, go to WAIT_PRE. Otherwise stay.
  - WAIT_PRE -> ENTER_SR.
  - ENTER_SR: CKE all 0 (held through WAIT_CLK), issue SRE (CS_n=0, RAS=0, CAS=0, WE=1), load T_CKSRE, go to WAIT_SRE.
  - WAIT_SRE -> CHANGE_CLK.
  - CHANGE_CLK: clk_sel=CLK_SEL_FAST (a set, not a toggle), load T_CKSRX, go to WAIT_CLK.
  - WAIT_CLK -> EXIT_SR.
  - EXIT_SR: CKE all 1 and kept 1 from here on, CS_n all 1 (DES), load T_XS, go to WAIT_XS.
  - WAIT_XS: CS_n held all 1, then -> SET_MR1.
  - SET_MR1: MRS (CS_n=0, RAS=CAS=WE=0), BA=01, BG=0, A[13:0]=MR1_CONF|1, load T_MOD, go to WAIT_MR1.
  - WAIT_MR1 -> SET_MR0.
  - SET_MR0: MRS, BA=00, A[13:0]=MR0_CONF with A8=1, load T_DLLK, go to WAIT_DLLK.
  - WAIT_DLLK: on its final cycle, dlle_done=1 (combinational, one cycle) and go to IDLE.
- restore_valid is ignored while busy, including the done cycle. A request held high re-triggers from IDLE on the following cycle.
- Total latency: done asserts T_PRECHARGE+T_CKSRE+T_CKSRX+T_XS+T_MOD+T_DLLK+11 cycles after the accept cycle (1896 cycles with defaults).

Decomposition:
- parameters.vh holds:
  - HIGH/LOW
  - BANK_WIDTH/BG_WIDTH/CS_WIDTH/CKE_WIDTH
  - lane index constants for RAS/CAS/WE
  - shared MR1_CONF default and timing defaults, so this block and the DLL-off sequencer stay consistent
- One sub-module, dll_wait_timer: load/value/decrement/zero flag, width 11.
- The command-slot encoding stays inline.

Test Plan:
- Reset, then idle: with rst=0 then 1 and no request, CKE=all 1, CS_n=all 1, clk_sel=1, busy=0, and no MC command ever issued.
- Full sequence with T_PRECHARGE=2, T_CKSRE=3, T_CKSRX=3, T_XS=4, T_MOD=2, T_DLLK=5 and a 1-cycle restore_valid at cycle 0:
  - PREA at cycle 1, SRE at cycle 5 with CKE low, clk_sel=0 at cycle 10, CKE high at cycle 15.
  - MR1 at cycle 21 with BA=01, A0=1, A8=1, A9=1.
  - MR0 at cycle 25 with BA=00, A8=1.
  - dlle_done high only at cycle 30, busy low at cycle 31.
- restore_valid pulsed at cycles 7 and 30 during the run: ignored, exactly one done. Held high continuously: a second PREA at cycle 32.
- rst=0 at cycle 12 (CKE low): CKE all 1, CS_n all 1, clk_sel=1, busy=0 asynchronously in the same cycle. A new request after release restarts from PREA.
- Default parameters: dlle_done exactly 1896 cycles after accept. Assert CKE is never low outside the SRE..SRX window and that no CS_n=0 lane is driven in WAIT_XS.

Source files
------------

// File: rtl/dll_restorer_pkg.sv
// dll_restorer_pkg: shared widths, lane map, timing defaults and FSM states for the DLL-on restore sequence
package dll_restorer_pkg;
    localparam logic HIGH = 1'b1;
    localparam logic LOW = 1'b0;
    localparam int LANES = 8;
    localparam int ADR_WIDTH = 17;
    localparam int BANK_WIDTH = 2;
    localparam int BG_WIDTH = 2;
    localparam int CS_WIDTH = 1;
    localparam int CKE_WIDTH = 1;
    localparam int RAS = 16;
    localparam int CAS = 15;
    localparam int WE = 14;
    localparam int A10 = 10;
    localparam int WAIT_WIDTH = 11;
    // Kept identical to the DLL-off sequencer so both directions agree on MR1 and timing
    localparam int DEF_T_PRECHARGE = 5;
    localparam int DEF_T_CKSRE = 300;
    localparam int DEF_T_CKSRX = 300;
    localparam int DEF_T_XS = 1000;
    localparam int DEF_T_MOD = 24;
    localparam int DEF_T_DLLK = 256;
    localparam logic [13:0] DEF_MR1_CONF = 14'b00001100000000;

    typedef enum logic [3:0] {
        IDLE, WAIT_PRE, ENTER_SR, WAIT_SRE, CHANGE_CLK, WAIT_CLK,
        EXIT_SR, WAIT_XS, SET_MR1, WAIT_MR1, SET_MR0, WAIT_DLLK
    } state_t;

    // Commands sit in lanes [1:0] of a pin; the remaining lanes carry the idle level
    function automatic logic [LANES-1:0] lanes(input logic v, input logic idle);
        return {{(LANES-2){idle}}, v, v};
    endfunction
endpackage

// File: rtl/dll_restorer_if.sv
// dll_restorer_if: start/status handshake plus the fabric-side DDR4 command lanes and clock select
interface dll_restorer_if;
    import dll_restorer_pkg::*;
    logic restore_valid;
    logic busy;
    logic dlle_done;
    logic clk_sel;
    logic [LANES-1:0] mc_ACT_n;
    logic [ADR_WIDTH*LANES-1:0] mc_ADR;
    logic [BANK_WIDTH*LANES-1:0] mc_BA;
    logic [BG_WIDTH*LANES-1:0] mc_BG;
    logic [CS_WIDTH*LANES-1:0] mc_CS_n;
    logic [CKE_WIDTH*LANES-1:0] mc_CKE;

    modport master (
        input restore_valid,
        output busy, dlle_done, clk_sel, mc_ACT_n, mc_ADR, mc_BA, mc_BG, mc_CS_n, mc_CKE
    );
    modport slave (
        output restore_valid,
        input busy, dlle_done, clk_sel, mc_ACT_n, mc_ADR, mc_BA, mc_BG, mc_CS_n, mc_CKE
    );
endinterface

// File: rtl/dll_restorer_wait_timer.sv
// dll_wait_timer: loadable down-counter that holds at zero and flags when it reads zero
module dll_wait_timer #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else cnt <= load ? value : zero ? cnt : cnt - W'(1);
    end

    assign zero = cnt == '0;
endmodule

// File: rtl/dll_restorer.sv
// dll_restorer: returns the DRAM from DLL-off slow-clock operation to DLL-on full speed
module dll_restorer
    import dll_restorer_pkg::*;
#(
    parameter int T_PRECHARGE = DEF_T_PRECHARGE,
    parameter int T_CKSRE = DEF_T_CKSRE,
    parameter int T_CKSRX = DEF_T_CKSRX,
    parameter int T_XS = DEF_T_XS,
    parameter int T_MOD = DEF_T_MOD,
    parameter int T_DLLK = DEF_T_DLLK,
    parameter logic [13:0] MR0_CONF = 14'h0000,
    parameter logic [13:0] MR1_CONF = DEF_MR1_CONF,
    parameter logic CLK_SEL_FAST = 1'b0
) (
    input logic clk,
    input logic rst,
    dll_restorer_if.master bus
);
    state_t state, nxt;
    logic load, zero, cs, sel_q, sel_d;
    logic [WAIT_WIDTH-1:0] val;
    logic [ADR_WIDTH-1:0] cmd;
    logic [BANK_WIDTH-1:0] ba;
    logic [ADR_WIDTH*LANES-1:0] adr_d, adr_q;
    logic [BANK_WIDTH*LANES-1:0] ba_d, ba_q;
    logic [CS_WIDTH*LANES-1:0] cs_d, cs_q;
    logic [CKE_WIDTH*LANES-1:0] cke_d, cke_q;

    dll_wait_timer #(.W(WAIT_WIDTH)) u_timer (
        .clk(clk), .rst(rst), .load(load), .value(val), .zero(zero)
    );

    always_comb begin
        nxt = state;
        load = LOW;
        val = '0;
        cmd = '1;
        ba = '0;
        cs = HIGH;
        cke_d = cke_q;
        sel_d = sel_q;
        case (state)
            IDLE: if (bus.restore_valid) begin
                nxt = WAIT_PRE;
                load = HIGH;
                val = WAIT_WIDTH'(T_PRECHARGE);
                cs = LOW;
                cmd[RAS] = LOW;
                cmd[CAS] = HIGH;
                cmd[WE] = LOW;
                cmd[A10] = HIGH;
            end
            WAIT_PRE: if (zero) nxt = ENTER_SR;
            ENTER_SR: begin
                nxt = WAIT_SRE;
                load = HIGH;
                val = WAIT_WIDTH'(T_CKSRE);
                cs = LOW;
                cmd[RAS] = LOW;
                cmd[CAS] = LOW;
                cke_d = '0;
            end
            WAIT_SRE: if (zero) nxt = CHANGE_CLK;
            CHANGE_CLK: begin
                nxt = WAIT_CLK;
                load = HIGH;
                val = WAIT_WIDTH'(T_CKSRX);
                sel_d = CLK_SEL_FAST;
            end
            WAIT_CLK: if (zero) nxt = EXIT_SR;
            EXIT_SR: begin
                nxt = WAIT_XS;
                load = HIGH;
                val = WAIT_WIDTH'(T_XS);
                cke_d = '1;
            end
            WAIT_XS: if (zero) nxt = SET_MR1;
            SET_MR1: begin
                nxt = WAIT_MR1;
                load = HIGH;
                val = WAIT_WIDTH'(T_MOD);
                cs = LOW;
                ba = BANK_WIDTH'(1);
                cmd = {3'b000, MR1_CONF | 14'h0001};
            end
            WAIT_MR1: if (zero) nxt = SET_MR0;
            SET_MR0: begin
                nxt = WAIT_DLLK;
                load = HIGH;
                val = WAIT_WIDTH'(T_DLLK);
                cs = LOW;
                cmd = {3'b000, MR0_CONF | 14'h0100};
            end
            WAIT_DLLK: if (zero) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    for (genvar p = 0; p < ADR_WIDTH; p++) begin : g_adr
        assign adr_d[p*LANES +: LANES] = lanes(cmd[p], HIGH);
    end
    for (genvar p = 0; p < BANK_WIDTH; p++) begin : g_ba
        assign ba_d[p*LANES +: LANES] = lanes(ba[p], LOW);
    end
    for (genvar p = 0; p < CS_WIDTH; p++) begin : g_cs
        assign cs_d[p*LANES +: LANES] = lanes(cs, HIGH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            adr_q <= '0;
            ba_q <= '0;
            cs_q <= '1;
            cke_q <= '1;
            sel_q <= ~CLK_SEL_FAST;
        end else begin
            state <= nxt;
            adr_q <= adr_d;
            ba_q <= ba_d;
            cs_q <= cs_d;
            cke_q <= cke_d;
            sel_q <= sel_d;
        end
    end

    assign bus.busy = state != IDLE;
    assign bus.dlle_done = state == WAIT_DLLK && zero;
    assign bus.mc_ACT_n = '1;
    assign bus.mc_ADR = adr_q;
    assign bus.mc_BA = ba_q;
    assign bus.mc_BG = '0;
    assign bus.mc_CS_n = cs_q;
    assign bus.mc_CKE = cke_q;
    assign bus.clk_sel = sel_q;
endmodule
